// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int DWORD_W = 64;
   localparam int ADDR_W  = 64;

   // Number of word-index bits for a power-of-two depth.
   function automatic int idx_bits(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the MEM stage (master) and the responder (slave).
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// a response transfers on a rising edge where rsp_valid && rsp_ready. Once a
// side raises valid, its payload stays stable until the transfer edge.
interface data_mem_responder_if;
   import dmem_pkg::*;

   logic               req_valid;
   logic               req_ready;
   logic               req_write;
   logic [ADDR_W-1:0]  req_addr;
   logic [DWORD_W-1:0] req_wdata;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [DWORD_W-1:0] rsp_rdata;
   logic               rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_array.sv
// Doubleword storage: synchronous write, combinational read, cleared on reset.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int IDX_W       = idx_bits(DEPTH_WORDS)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               we_i,
   input  logic [IDX_W-1:0]   idx_i,
   input  logic [DWORD_W-1:0] wdata_i,
   output logic [DWORD_W-1:0] rdata_o
);

   logic [DWORD_W-1:0] mem_q [DEPTH_WORDS];

   // Clear every entry on reset; otherwise commit a write when enabled.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[idx_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder with a fixed access latency.
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   data_mem_responder_if.slave  bus,
   output state_e               state_o
);

   localparam int         IDX_W    = idx_bits(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_e             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               write_q, write_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DWORD_W-1:0] wdata_q, wdata_d;
   logic [DWORD_W-1:0] rdata_q, rdata_d;
   logic               err_q, err_d;

   logic               mem_we;
   logic [DWORD_W-1:0] mem_rdata;
   logic               addr_err;

   // Misaligned or beyond the stored range; such accesses never touch memory.
   assign addr_err = (|addr_q[2:0]) || (|addr_q[ADDR_W-1:3+IDX_W]);

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clk     (clk),
      .reset   (reset),
      .we_i    (mem_we),
      .idx_i   (addr_q[3+IDX_W-1:3]),
      .wdata_i (wdata_q),
      .rdata_o (mem_rdata)
   );

   // Next-state: accept in IDLE, count down in BUSY, access at zero, hold in RESP.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      mem_we  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               write_d = bus.req_write;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               cnt_d   = CNT_INIT;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q == 4'd0) begin
               err_d   = addr_err;
               rdata_d = (!write_q && !addr_err) ? mem_rdata : '0;
               mem_we  = write_q && !addr_err;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset drops any in-flight request.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign bus.req_ready = (state_q == IDLE);
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;
   assign state_o       = state_q;

endmodule
